instr_encoder: RTL
==================

# instr_encoder

Streaming RISC-V RV32I instruction encoder, the inverse of the core's immediate extraction path. It accepts decoded fields (format, opcode, registers, funct fields, and a full 32-bit immediate) and produces the packed 32-bit instruction word. Each word carries a sequential instruction-memory address, ready for the instruction-memory preload/test-program writer. Immediates that cannot be represented in the selected format are flagged, counted, and replaced by a NOP.

## Interface
- `BASE_ADDR`, default 32'h0000_0000: address assigned to the first instruction after reset or `clear`.
- `ERR_W`, default 16: width of the error counter.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `clear`  in  1  synchronous restart of address and error counter.
- `in_valid`  in  1  input fields valid.
- `in_ready`  out  1  encoder can accept input this cycle.
- `fmt`  in  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6=I-shift; 7 is illegal.
- `opcode`  in  7  placed at [6:0].
- `rd`, `rs1`, `rs2`  in  5 each  register fields.
- `funct3`  in  3  placed at [14:12].
- `funct7`  in  7  placed at [31:25] for the R and I-shift formats.
- `imm`  in  32  full signed byte-offset or value; for U, the final upper value, e.g. 0x12345000.
- `out_valid`  out  1  output word valid.
- `out_ready`  in  1  consumer accepts output.
- `out_instr`  out  32  encoded instruction.
- `out_addr`  out  32  address of `out_instr`.
- `out_err`  out  1  immediate out of range or illegal `fmt`.
- `err_count`  out  ERR_W  saturating count of flagged words.

## Operation
- Field placement (unused fields are zero):
  - R: funct7|rs2|rs1|f3|rd|op.
  - I: imm[11:0]|rs1|f3|rd|op.
  - S: imm[11:5]|rs2|rs1|f3|imm[4:0]|op.
  - B: imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op.
  - U: imm[31:12]|rd|op.
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op.
  - I-shift: funct7|imm[4:0]|rs1|f3|rd|op.
- Legality rules:
  - I and S: imm[31:11] all equal.
  - B: imm[0]=0 and imm[31:12] all equal.
  - J: imm[0]=0 and imm[31:20] all equal.
  - U: imm[11:0]=0.
  - I-shift: imm[31:5]=0.
  - R: imm is ignored and always legal.
  - fmt=7: always illegal.
- Illegal word: `out_instr`=32'h0000_0013 (addi x0,x0,0), `out_err`=1. The word still consumes an address.
- Round-trip property: every legal word, fed to the core's immediate extractor with the matching ImmSrc/isLUI, returns `imm` exactly.
- Address counter `next_addr`:
  - Loads `BASE_ADDR` on reset or `clear`.
  - On each accepted input, it is copied to the output register and then incremented by 4.
  - Wraps modulo 2^32.
- `err_count` increments on each accepted illegal input and saturates at all-ones.
- Output register behaviour:
  - Holds a single word.
  - States: EMPTY (`out_valid`=0) and FULL (`out_valid`=1).
  - EMPTY→FULL on input accept.
  - FULL→EMPTY on output transfer with no input accept.
  - FULL→FULL on simultaneous accept and transfer, or on a stall.

## Timing
- `in_ready` = !`out_valid` || `out_ready`, forced to 0 while `rst_n`=0 or `clear`=1. The only input-to-output combinational path is `out_ready`→`in_ready`.
- Input is accepted on a rising edge with `in_valid`&&`in_ready`. The encoded word appears on the next cycle (latency 1).
- Throughput is 1 word per cycle when `out_ready` is held high.
- While `out_valid`=1 and `out_ready`=0, `out_instr`, `out_addr` and `out_err` hold stable.
- Reset values: `out_valid`=0, `out_instr`=0, `out_addr`=`BASE_ADDR`, `out_err`=0, `err_count`=0, `next_addr`=`BASE_ADDR`.
- Reset asserted mid-stream discards any pending output word.
- `clear`=1 has the same effect as reset on `out_valid`, `next_addr` and `err_count`, and wins over a simultaneous handshake. The pending word is dropped and no transfer is counted.
- `next_addr` wrap: an input at 0xFFFF_FFFC produces `out_addr`=0xFFFF_FFFC, and the next input gets 0x0000_0000.

## Test plan
- Reset, then encode with `out_ready`=1:
  - I addi, rd=5, rs1=6, f3=0, imm=0xFFFF_FFFF → 0xFFF3_0293, addr 0x0.
  - U lui, rd=10, imm=0x1234_5000 → 0x1234_5537, addr 0x4.
- B beq, rs1=1, rs2=2, imm=8 → 0x0020_8463.
- J jal, rd=1, imm=0x800 → 0x0010_00EF.
- Both results must round-trip through the core's extractor to 8 and 0x800 respectively.
- Range errors:
  - I with imm=2048 → 0x0000_0013, `out_err`=1.
  - B with imm=3 → NOP, `out_err`=1.
  - `err_count` reaches 2 and addresses still advance.
- Backpressure:
  - Hold `in_valid`=1 and drop `out_ready` for 3 cycles → `in_ready`=0 and the output is stable.
  - On release, addresses 0x0, 0x4, 0x8 arrive in order with no loss or duplication.
- Pulse `clear` while FULL and stalled → `out_valid`=0, `err_count`=0. The next word gets `BASE_ADDR`.
- Assert `rst_n`=0 mid-stream for 1 cycle → all outputs return to reset values. Set `BASE_ADDR`=0xFFFF_FFFC and send 2 words → addresses 0xFFFF_FFFC then 0x0.

Source files
------------

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// instr_encoder : packs decoded RV32I fields into 32-bit words with addresses
// Revision 1.0
// ============================================================================
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned ERR_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       fmt,
  input  logic [6:0]       opcode,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic [31:0]      imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [31:0]      out_addr,
  output logic             out_err,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [2:0]  FMT_R      = 3'd0;
  localparam logic [2:0]  FMT_I      = 3'd1;
  localparam logic [2:0]  FMT_S      = 3'd2;
  localparam logic [2:0]  FMT_B      = 3'd3;
  localparam logic [2:0]  FMT_U      = 3'd4;
  localparam logic [2:0]  FMT_J      = 3'd5;
  localparam logic [2:0]  FMT_ISHIFT = 3'd6;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam logic [31:0] ADDR_STEP  = 32'd4;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]  state;
  logic [0:0]  state_nxt;
  logic        accept;
  logic        transfer;
  logic [31:0] next_addr;
  logic [31:0] enc_word;
  logic        enc_legal;
  logic        imm_hi11_same;
  logic        imm_hi12_same;
  logic        imm_hi20_same;

  // Sign-extension checks: the upper bits must all replicate the top kept bit.
  assign imm_hi11_same = (&imm[31:11]) || (~|imm[31:11]);
  assign imm_hi12_same = (&imm[31:12]) || (~|imm[31:12]);
  assign imm_hi20_same = (&imm[31:20]) || (~|imm[31:20]);

  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b0;
    case (fmt)
      FMT_R: begin
        enc_word  = {funct7, rs2, rs1, funct3, rd, opcode};
        enc_legal = 1'b1;
      end
      FMT_I: begin
        enc_word  = {imm[11:0], rs1, funct3, rd, opcode};
        enc_legal = imm_hi11_same;
      end
      FMT_S: begin
        enc_word  = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        enc_legal = imm_hi11_same;
      end
      FMT_B: begin
        enc_word  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        enc_legal = imm_hi12_same && !imm[0];
      end
      FMT_U: begin
        enc_word  = {imm[31:12], rd, opcode};
        enc_legal = (imm[11:0] == 12'd0);
      end
      FMT_J: begin
        enc_word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        enc_legal = imm_hi20_same && !imm[0];
      end
      FMT_ISHIFT: begin
        enc_word  = {funct7, imm[4:0], rs1, funct3, rd, opcode};
        enc_legal = (imm[31:5] == 27'd0);
      end
      default: begin
        enc_word  = '0;
        enc_legal = 1'b0;
      end
    endcase
  end

  assign accept   = in_valid && in_ready;
  assign transfer = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: if (accept) state_nxt = ST_FULL;
      ST_FULL:  if (transfer && !accept) state_nxt = ST_EMPTY;
      default:  state_nxt = ST_EMPTY;
    endcase
  end

  // Only out_ready reaches in_ready combinationally; reset and clear gate it off.
  always_comb begin
    out_valid = (state == ST_FULL);
    in_ready  = rst_n && !clear && ((state == ST_EMPTY) || out_ready);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_instr <= '0;
      out_addr  <= BASE_ADDR;
      out_err   <= 1'b0;
    end else if (accept) begin
      out_instr <= enc_legal ? enc_word : NOP_INSTR;
      out_addr  <= next_addr;
      out_err   <= !enc_legal;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      next_addr <= BASE_ADDR;
      err_count <= '0;
    end else if (accept) begin
      next_addr <= next_addr + ADDR_STEP;
      if (!enc_legal && (err_count != {ERR_W{1'b1}})) begin
        err_count <= err_count + ERR_W'(1);
      end
    end
  end

endmodule
`default_nettype wire
